// File: rtl/draw_player.sv
`default_nettype none
// ============================================================================
//  Module   : draw_player
//  Purpose  : Overlays a square player sprite on the incoming VGA stream and
//             moves it one pixel per frame during vertical blanking.
//             Optional wall collision (restore previous position and pulse
//             hit) is compiled in when PLAYER_COLLISION_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module draw_player #(
    parameter int          START_X    = 497,
    parameter int          START_Y    = 369,
    parameter int          SIZE       = 30,
    parameter logic [11:0] PLAYER_RGB = 12'h0_f_f,
    parameter logic [11:0] WALL_RGB   = 12'h0_0_f,
    parameter int          HOR_PIXELS = 1024,
    parameter int          VER_PIXELS = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vga_in_vcount_i,
    input  logic        vga_in_vsync_i,
    input  logic        vga_in_vblnk_i,
    input  logic [10:0] vga_in_hcount_i,
    input  logic        vga_in_hsync_i,
    input  logic        vga_in_hblnk_i,
    input  logic [11:0] vga_in_rgb_i,
    output logic [10:0] vga_out_vcount_o,
    output logic        vga_out_vsync_o,
    output logic        vga_out_vblnk_o,
    output logic [10:0] vga_out_hcount_o,
    output logic        vga_out_hsync_o,
    output logic        vga_out_hblnk_o,
    output logic [11:0] vga_out_rgb_o,
    input  logic        enable_i,
    input  logic        dir_up_i,
    input  logic        dir_down_i,
    input  logic        dir_left_i,
    input  logic        dir_right_i,
    output logic [10:0] pos_x_o,
    output logic [10:0] pos_y_o,
    output logic        hit_o
);

    // Legal range of the top-left corner, keeping a 6-pixel margin to the edge
    localparam logic [10:0] c_x_min = 11'd6;
    localparam logic [10:0] c_y_min = 11'd6;
    localparam logic [10:0] c_x_max = 11'(HOR_PIXELS - 6 - SIZE);
    localparam logic [10:0] c_y_max = 11'(VER_PIXELS - 6 - SIZE);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        DECIDE  = 2'd1,
        MOVE    = 2'd2,
        RESTORE = 2'd3
    } state_t;

    state_t      state_q;
    logic [10:0] pos_x_q, pos_y_q;
    logic [10:0] prev_x_q, prev_y_q;
    logic [10:0] pos_x_d, pos_y_d;
    logic        hit_q;
    logic        coll_flag_q;

    logic        w_in_box;
    logic        w_frame_tick;
    logic        w_wall_px;
    logic        w_coll_set;

    // Box test uses 12-bit upper bounds so pos+SIZE can never wrap
    assign w_in_box = !vga_in_hblnk_i && !vga_in_vblnk_i
                   && (vga_in_hcount_i >= pos_x_q)
                   && ({1'b0, vga_in_hcount_i} < ({1'b0, pos_x_q} + 12'(SIZE)))
                   && (vga_in_vcount_i >= pos_y_q)
                   && ({1'b0, vga_in_vcount_i} < ({1'b0, pos_y_q} + 12'(SIZE)));

    // First pixel of the first vblank line: one strobe per frame
    assign w_frame_tick = (vga_in_vcount_i == 11'(VER_PIXELS)) && (vga_in_hcount_i == 11'd0);

    assign w_wall_px = w_in_box && (vga_in_rgb_i == WALL_RGB);

`ifdef PLAYER_COLLISION_EN
    assign w_coll_set = w_wall_px;
`else
    // Wall pixels are still recognised, but can never raise the flag
    assign w_coll_set = w_wall_px & 1'b0;
`endif

    // Candidate next position: one axis, fixed priority, out-of-range steps dropped
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (enable_i) begin
            if (dir_up_i) begin
                if (pos_y_q > c_y_min) pos_y_d = pos_y_q - 11'd1;
            end else if (dir_down_i) begin
                if (pos_y_q < c_y_max) pos_y_d = pos_y_q + 11'd1;
            end else if (dir_left_i) begin
                if (pos_x_q > c_x_min) pos_x_d = pos_x_q - 11'd1;
            end else if (dir_right_i) begin
                if (pos_x_q < c_x_max) pos_x_d = pos_x_q + 11'd1;
            end
        end
    end

    // One-cycle video pipeline: timing delayed, rgb replaced inside the box
    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_out_vcount_o <= '0;
            vga_out_vsync_o  <= 1'b0;
            vga_out_vblnk_o  <= 1'b0;
            vga_out_hcount_o <= '0;
            vga_out_hsync_o  <= 1'b0;
            vga_out_hblnk_o  <= 1'b0;
            vga_out_rgb_o    <= '0;
        end else begin
            vga_out_vcount_o <= vga_in_vcount_i;
            vga_out_vsync_o  <= vga_in_vsync_i;
            vga_out_vblnk_o  <= vga_in_vblnk_i;
            vga_out_hcount_o <= vga_in_hcount_i;
            vga_out_hsync_o  <= vga_in_hsync_i;
            vga_out_hblnk_o  <= vga_in_hblnk_i;
            vga_out_rgb_o    <= w_in_box ? PLAYER_RGB : vga_in_rgb_i;
        end
    end

    // Movement FSM: scan for walls during the frame, then move or restore in vblank
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SCAN;
            pos_x_q     <= 11'(START_X);
            pos_y_q     <= 11'(START_Y);
            prev_x_q    <= 11'(START_X);
            prev_y_q    <= 11'(START_Y);
            hit_q       <= 1'b0;
            coll_flag_q <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (w_coll_set) coll_flag_q <= 1'b1;
                    if (w_frame_tick) state_q <= DECIDE;
                end
                DECIDE: begin
                    if (coll_flag_q) begin
                        state_q <= RESTORE;
                        hit_q   <= 1'b1;    // high for the whole RESTORE cycle
                    end else begin
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    prev_x_q    <= pos_x_q;
                    prev_y_q    <= pos_y_q;
                    pos_x_q     <= pos_x_d;
                    pos_y_q     <= pos_y_d;
                    coll_flag_q <= 1'b0;
                    state_q     <= SCAN;
                end
                RESTORE: begin
                    pos_x_q     <= prev_x_q;
                    pos_y_q     <= prev_y_q;
                    coll_flag_q <= 1'b0;
                    state_q     <= SCAN;
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign pos_x_o = pos_x_q;
    assign pos_y_o = pos_y_q;
    assign hit_o   = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_player
//  Purpose  : Directed self-checking bench for draw_player. Expectations for
//             the collision case follow PLAYER_COLLISION_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_draw_player;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vc, hc;
    logic        vs, vb, hs, hb;
    logic [11:0] rgb;
    logic [10:0] vc_o, hc_o;
    logic        vs_o, vb_o, hs_o, hb_o;
    logic [11:0] rgb_o;
    logic        en, up, dn, lf, rt;
    logic [10:0] pos_x, pos_y;
    logic        hit;

    int n_cmp   = 0;
    int n_bad   = 0;
    int hit_cnt = 0;

    always #5 clk = ~clk;

    draw_player dut (
        .clk              (clk),
        .rst              (rst),
        .vga_in_vcount_i  (vc),
        .vga_in_vsync_i   (vs),
        .vga_in_vblnk_i   (vb),
        .vga_in_hcount_i  (hc),
        .vga_in_hsync_i   (hs),
        .vga_in_hblnk_i   (hb),
        .vga_in_rgb_i     (rgb),
        .vga_out_vcount_o (vc_o),
        .vga_out_vsync_o  (vs_o),
        .vga_out_vblnk_o  (vb_o),
        .vga_out_hcount_o (hc_o),
        .vga_out_hsync_o  (hs_o),
        .vga_out_hblnk_o  (hb_o),
        .vga_out_rgb_o    (rgb_o),
        .enable_i         (en),
        .dir_up_i         (up),
        .dir_down_i       (dn),
        .dir_left_i       (lf),
        .dir_right_i      (rt),
        .pos_x_o          (pos_x),
        .pos_y_o          (pos_y),
        .hit_o            (hit)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge and count hit pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (hit === 1'b1) hit_cnt++;
    endtask

    task automatic idle_px();
        hc = 11'd1100; vc = 11'd0; hb = 1'b1; vb = 1'b0; rgb = 12'h000; hs = 1'b0; vs = 1'b0;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c, input logic blank);
        hc = h; vc = v; hb = blank; vb = 1'b0; rgb = c;
    endtask

    task automatic set_dir(input logic e, input logic u, input logic d, input logic l, input logic r);
        en = e; up = u; dn = d; lf = l; rt = r;
    endtask

    // Frame tick, DECIDE, MOVE/RESTORE, then one SCAN cycle for margin
    task automatic frame();
        hc = 11'd0; vc = 11'd768; vb = 1'b1; hb = 1'b0; rgb = 12'h000;
        tick();
        hc = 11'd1;
        tick();
        tick();
        idle_px();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    logic [25:0] exp_t;
    int          hits_before;
    logic [10:0] exp_x;
    int          exp_hits;

    initial begin
        // Reset with non-zero inputs so zeroed outputs are meaningful
        rst = 1'b0;
        set_dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hc = 11'd5; vc = 11'd7; hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b1; rgb = 12'h123;
        tick();
        check("rst_pos_x", 36'(pos_x), 36'd497);
        check("rst_pos_y", 36'(pos_y), 36'd369);
        check("rst_hit", 36'(hit), 36'd0);
        check("rst_rgb", 36'(rgb_o), 36'h000);
        check("rst_timing", 36'({vc_o, vs_o, vb_o, hc_o, hs_o, hb_o}), 36'd0);
        rst = 1'b1;
        idle_px();
        tick();

        // Timing pass-through, two distinct vectors to pin latency at one cycle
        hc = 11'd20; vc = 11'd10; hs = 1'b0; vs = 1'b1; hb = 1'b1; vb = 1'b0; rgb = 12'habc;
        exp_t = {11'd10, 1'b1, 1'b0, 11'd20, 1'b0, 1'b1};
        tick();
        check("timing_a", 36'({vc_o, vs_o, vb_o, hc_o, hs_o, hb_o}), 36'(exp_t));
        check("rgb_blank_pass", 36'(rgb_o), 36'habc);
        hc = 11'd1030; vc = 11'd770; hs = 1'b1; vs = 1'b0; hb = 1'b0; vb = 1'b1;
        exp_t = {11'd770, 1'b0, 1'b1, 11'd1030, 1'b1, 1'b0};
        tick();
        check("timing_b", 36'({vc_o, vs_o, vb_o, hc_o, hs_o, hb_o}), 36'(exp_t));

        // Overlay: box spans x 497..526, y 369..398
        pix(11'd497, 11'd369, 12'h000, 1'b0); tick();
        check("ovl_corner_tl", 36'(rgb_o), 36'h0ff);
        pix(11'd527, 11'd369, 12'h000, 1'b0); tick();
        check("ovl_right_edge", 36'(rgb_o), 36'h000);
        pix(11'd527, 11'd369, 12'h5a5, 1'b0); tick();
        check("ovl_right_pass", 36'(rgb_o), 36'h5a5);
        pix(11'd526, 11'd398, 12'h5a5, 1'b0); tick();
        check("ovl_corner_br", 36'(rgb_o), 36'h0ff);
        pix(11'd526, 11'd399, 12'h5a5, 1'b0); tick();
        check("ovl_below", 36'(rgb_o), 36'h5a5);
        pix(11'd496, 11'd380, 12'h321, 1'b0); tick();
        check("ovl_left", 36'(rgb_o), 36'h321);
        pix(11'd500, 11'd380, 12'h321, 1'b1); tick();
        check("ovl_blanked", 36'(rgb_o), 36'h321);
        idle_px(); tick();

        // Movement priority and enable
        set_dir(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        frames(3);
        check("prio_up_y", 36'(pos_y), 36'd366);
        check("prio_up_x", 36'(pos_x), 36'd497);
        set_dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        check("disabled_y", 36'(pos_y), 36'd366);
        set_dir(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        check("down_y", 36'(pos_y), 36'd367);
        set_dir(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        frame();
        check("left_over_right", 36'(pos_x), 36'd496);
        set_dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame();
        check("right_x", 36'(pos_x), 36'd497);
        check("no_hit_moves", 36'(hit_cnt), 36'd0);

        // Wall pixel inside the box; last move was 496 -> 497
        hits_before = hit_cnt;
        pix(11'd500, 11'd370, 12'h00f, 1'b0); tick();
        check("wall_overlay", 36'(rgb_o), 36'h0ff);
        idle_px();
        set_dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame();
`ifdef PLAYER_COLLISION_EN
        exp_x = 11'd496;
        exp_hits = 1;
`else
        exp_x = 11'd498;
        exp_hits = 0;
`endif
        check("coll_pos_x", 36'(pos_x), 36'(exp_x));
        check("coll_pos_y", 36'(pos_y), 36'd367);
        check("coll_hits", 36'(hit_cnt - hits_before), 36'(exp_hits));
        set_dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame();
        check("coll_cleared_x", 36'(pos_x), 36'(exp_x));
        check("coll_single_hit", 36'(hit_cnt - hits_before), 36'(exp_hits));

        // Clamps at each bound
        set_dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frames(600);
        check("clamp_right", 36'(pos_x), 36'd988);
        frames(2);
        check("clamp_right_hold", 36'(pos_x), 36'd988);
        set_dir(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        frames(1000);
        check("clamp_left", 36'(pos_x), 36'd6);
        set_dir(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(400);
        check("clamp_up", 36'(pos_y), 36'd6);
        set_dir(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(800);
        check("clamp_down", 36'(pos_y), 36'd732);

        // Reset landing on the DECIDE cycle aborts the pending move
        hits_before = hit_cnt;
        set_dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hc = 11'd0; vc = 11'd768; vb = 1'b1; hb = 1'b0; rgb = 12'h000;
        tick();
        hc = 11'd1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_pos_x", 36'(pos_x), 36'd497);
        check("abort_pos_y", 36'(pos_y), 36'd369);
        tick();
        tick();
        idle_px();
        tick();
        check("abort_no_move_x", 36'(pos_x), 36'd497);
        check("abort_no_hit", 36'(hit_cnt - hits_before), 36'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
